// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned LATENCY_MAX = 15;

  // Flags a byte address that is not word aligned or lies beyond the stored words.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned addr_w);
    logic [31:0] hi;
    hi = addr >> (addr_w + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_word_array.sv
// Single-port synchronous word RAM with registered read data; contents survive reset.
module dmem_word_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
    rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the CPU load/store interface: one request at a time, fixed latency,
// single-cycle response pulse and a pipeline stall while the access is outstanding.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned ADDR_W  = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [31:0]       req_addr_i,
  input  logic [WORD_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [WORD_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              stall_o
);

  localparam int unsigned CntW = $clog2(LATENCY_MAX + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] hold_q, hold_d;

  logic              accept;
  logic              enter_resp;
  logic              cur_we;
  logic              cur_err;
  logic [31:0]       cur_addr;
  logic [WORD_W-1:0] cur_wdata;
  logic              mem_we;
  logic [WORD_W-1:0] arr_rdata;

  assign accept = req_valid_i & (state_q == StIdle);

  // With LATENCY=1 the commit edge is the acceptance edge, so the live request is used.
  always_comb begin
    if (state_q == StIdle) begin
      cur_we    = req_we_i;
      cur_addr  = req_addr_i;
      cur_wdata = req_wdata_i;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
    cur_err = addr_err(cur_addr, ADDR_W);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    hold_d     = hold_q;
    enter_resp = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          if (LATENCY == 1) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(LATENCY - 2);
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
        hold_d  = rsp_rdata_o;
      end
      default: state_d = StIdle;
    endcase
    if (enter_resp) begin
      err_d = cur_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  // Reset on the commit edge must not let a pending store reach the array.
  assign mem_we = enter_resp & cur_we & ~cur_err & ~rst_i;

  dmem_word_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .idx_i   (cur_addr[ADDR_W+1:2]),
    .wdata_i (cur_wdata),
    .rdata_o (arr_rdata)
  );

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_err_o   = err_q;
  assign rsp_rdata_o = (state_q == StResp) ? (err_q ? '0 : arr_rdata) : hold_q;
  assign stall_o     = (req_valid_i | (state_q != StIdle)) & ~rsp_valid_o;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=3 instance and a LATENCY=1 instance.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  int          n_cmp = 0;
  int          n_fail = 0;

  logic        v3, we3, rdy3, rv3, er3, st3;
  logic [31:0] a3, wd3, rd3;
  logic        v1, we1, rdy1, rv1, er1, st1;
  logic [31:0] a1, wd1, rd1;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(128), .LATENCY(3), .ADDR_W(7)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v3), .req_ready_o(rdy3), .req_we_i(we3),
    .req_addr_i(a3), .req_wdata_i(wd3), .rsp_valid_o(rv3), .rsp_rdata_o(rd3),
    .rsp_err_o(er3), .stall_o(st3)
  );

  dmem_responder #(.DEPTH(128), .LATENCY(1), .ADDR_W(7)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v1), .req_ready_o(rdy1), .req_we_i(we1),
    .req_addr_i(a1), .req_wdata_i(wd1), .rsp_valid_o(rv1), .rsp_rdata_o(rd1),
    .rsp_err_o(er1), .stall_o(st1)
  );

  // Drives one request into the LATENCY=3 instance starting at a negedge with the DUT idle,
  // measures the cycles from acceptance to the response, and returns at an idle negedge.
  task automatic access3(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic mid_change, output logic [31:0] rdata, output logic err,
                         output int lat, output int stall_bad);
    stall_bad = 0;
    lat       = -1;
    rdata     = 32'hFFFF_FFFF;
    err       = 1'bx;
    v3 = 1'b1; we3 = we; a3 = addr; wd3 = wdata;
    #1;
    if (st3 !== 1'b1 || rdy3 !== 1'b1) stall_bad++;
    @(posedge clk);
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (rv3 === 1'b1) begin
        lat   = k;
        rdata = rd3;
        err   = er3;
        if (st3 !== 1'b0) stall_bad++;
      end else if (st3 !== 1'b1) begin
        stall_bad++;
      end
      if (mid_change && k == 1) begin
        we3 = 1'b1; a3 = 32'h14; wd3 = 32'hBAD0_BAD0;
      end
    end
    v3 = 1'b0; we3 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    v3 = 1'b0; we3 = 1'b0; a3 = '0; wd3 = '0;
    v1 = 1'b0; we1 = 1'b0; a1 = '0; wd1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (rdy3 !== 1'b1 || rv3 !== 1'b0 || rd3 !== 32'h0 || st3 !== 1'b0 || er3 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle3 c=%0d: ready=%b rv=%b rdata=%h stall=%b err=%b, want 1 0 0 0 0",
                 c, rdy3, rv3, rd3, st3, er3);
      end
      n_cmp++;
      if (rdy1 !== 1'b1 || rv1 !== 1'b0 || rd1 !== 32'h0 || st1 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle1 c=%0d: ready=%b rv=%b rdata=%h stall=%b, want 1 0 0 0",
                 c, rdy1, rv1, rd1, st1);
      end
    end
  endtask

  task automatic test_write_read;
    logic [31:0] rd;
    logic        er;
    int          lat, sb;
    access3(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, rd, er, lat, sb);
    n_cmp++;
    if (lat != 3 || er !== 1'b0 || sb != 0) begin
      n_fail++;
      $display("FAIL write_10: latency=%0d err=%b stall_errs=%0d, want 3 0 0", lat, er, sb);
    end
    access3(1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat, sb);
    n_cmp++;
    if (lat != 3 || er !== 1'b0 || rd !== 32'hDEAD_BEEF || sb != 0) begin
      n_fail++;
      $display("FAIL read_10: latency=%0d err=%b rdata=%h stall_errs=%0d, want 3 0 deadbeef 0",
               lat, er, rd, sb);
    end
    n_cmp++;
    if (rd3 !== 32'hDEAD_BEEF || rv3 !== 1'b0) begin
      n_fail++;
      $display("FAIL rdata_hold: rdata=%h rv=%b, want deadbeef 0", rd3, rv3);
    end
    // Known contents used by later scenarios.
    access3(1'b1, 32'h0, 32'h0000_A5A5, 1'b0, rd, er, lat, sb);
    access3(1'b1, 32'h20, 32'hCAFE_0020, 1'b0, rd, er, lat, sb);
    access3(1'b1, 32'h14, 32'h1414_1414, 1'b0, rd, er, lat, sb);
    n_cmp++;
    if (lat != 3 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL write_14: latency=%0d err=%b, want 3 0", lat, er);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_rd [6];
    logic        op_we  [6];
    logic [31:0] op_a   [6];
    logic [31:0] op_d   [6];
    int          idx = 0;
    int          acc_c = -10;
    int          last_pulse = -10;
    logic        prev_rv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      op_we[i] = 1'b1; op_a[i] = 32'h40 + 32'(4 * i); op_d[i] = 32'h1000_0000 + 32'(i);
      op_we[i+3] = 1'b0; op_a[i+3] = 32'h40 + 32'(4 * i); op_d[i+3] = 32'h0;
      exp_rd[i+3] = 32'h1000_0000 + 32'(i);
    end
    v1 = 1'b1; we1 = op_we[0]; a1 = op_a[0]; wd1 = op_d[0];
    for (int c = 0; c < 40 && idx < 6; c++) begin
      if (c > 0) @(negedge clk);
      if (rv1 === 1'b1) begin
        n_cmp++;
        if (c - acc_c != 1 || prev_rv !== 1'b0 || er1 !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_timing op=%0d: lat=%0d prev_rv=%b err=%b, want 1 0 0",
                   idx, c - acc_c, prev_rv, er1);
        end
        if (idx > 0) begin
          n_cmp++;
          if (c - last_pulse != 2) begin
            n_fail++;
            $display("FAIL b2b_spacing op=%0d: gap=%0d, want 2", idx, c - last_pulse);
          end
        end
        if (!op_we[idx]) begin
          n_cmp++;
          if (rd1 !== exp_rd[idx]) begin
            n_fail++;
            $display("FAIL b2b_rdata op=%0d: rdata=%h, want %h", idx, rd1, exp_rd[idx]);
          end
        end
        last_pulse = c;
        idx++;
        if (idx < 6) begin
          we1 = op_we[idx]; a1 = op_a[idx]; wd1 = op_d[idx];
        end else begin
          v1 = 1'b0; we1 = 1'b0;
        end
      end
      prev_rv = rv1;
      if (v1 === 1'b1 && rdy1 === 1'b1) acc_c = c;
    end
    n_cmp++;
    if (idx != 6) begin
      n_fail++;
      $display("FAIL b2b_timeout: responses=%0d, want 6", idx);
    end
    v1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_errors;
    logic [31:0] rd;
    logic        er;
    int          lat, sb;
    access3(1'b1, 32'h12, 32'h7777_7777, 1'b0, rd, er, lat, sb);
    n_cmp++;
    if (lat != 3 || er !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL misaligned_12: latency=%0d err=%b rdata=%h, want 3 1 0", lat, er, rd);
    end
    access3(1'b1, 32'h200, 32'h55, 1'b0, rd, er, lat, sb);
    n_cmp++;
    if (lat != 3 || er !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL range_200: latency=%0d err=%b rdata=%h, want 3 1 0", lat, er, rd);
    end
    access3(1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat, sb);
    n_cmp++;
    if (er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL err_keep_10: err=%b rdata=%h, want 0 deadbeef", er, rd);
    end
    access3(1'b0, 32'h0, 32'h0, 1'b0, rd, er, lat, sb);
    n_cmp++;
    if (er !== 1'b0 || rd !== 32'h0000_A5A5) begin
      n_fail++;
      $display("FAIL err_keep_0: err=%b rdata=%h, want 0 0000a5a5", er, rd);
    end
  endtask

  task automatic test_reset_mid_wait;
    logic [31:0] rd;
    logic        er;
    int          lat, sb;
    int          pulses = 0;
    v3 = 1'b1; we3 = 1'b1; a3 = 32'h20; wd3 = 32'h0000_1234;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    v3 = 1'b0; we3 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (rdy3 !== 1'b1 || rv3 !== 1'b0 || st3 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait_idle: ready=%b rv=%b stall=%b, want 1 0 0", rdy3, rv3, st3);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rv3 === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL rst_wait_norsp: pulses=%0d, want 0", pulses);
    end
    access3(1'b0, 32'h20, 32'h0, 1'b0, rd, er, lat, sb);
    n_cmp++;
    if (lat != 3 || er !== 1'b0 || rd !== 32'hCAFE_0020) begin
      n_fail++;
      $display("FAIL rst_wait_mem: latency=%0d err=%b rdata=%h, want 3 0 cafe0020", lat, er, rd);
    end
  endtask

  task automatic test_req_change;
    logic [31:0] rd;
    logic        er;
    int          lat, sb;
    access3(1'b0, 32'h10, 32'h0, 1'b1, rd, er, lat, sb);
    n_cmp++;
    if (lat != 3 || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL change_rsp: latency=%0d err=%b rdata=%h, want 3 0 deadbeef", lat, er, rd);
    end
    access3(1'b0, 32'h14, 32'h0, 1'b0, rd, er, lat, sb);
    n_cmp++;
    if (rd !== 32'h1414_1414) begin
      n_fail++;
      $display("FAIL change_nowrite_14: rdata=%h, want 14141414", rd);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_errors();
    test_reset_mid_wait();
    test_req_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
